// File: rtl/demux_router_if.sv
// Stream bundle for demux_router: one valid/ready input channel carrying a
// select bit, and two valid/ready output channels.
interface demux_router_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;

  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;

  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;

  // Environment side: upstream source plus both result sinks.
  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid
  );

  // Router side.
  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid
  );
endinterface

// File: rtl/demux_router.sv
// Two-way stream demultiplexer: steers each input word by its select bit into
// one of two one-entry output buffers, with saturating per-channel counters.
module demux_router #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_router_if.slave    bus,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  buf_state_e       state_q [2];
  buf_state_e       state_d [2];
  logic [WIDTH-1:0] data_q  [2];
  logic [WIDTH-1:0] data_d  [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];

  logic [1:0] sink_ready;
  logic [1:0] fill;
  logic [1:0] drain;

  assign sink_ready = {bus.out1_ready, bus.out0_ready};

  // A buffer can take a word if it is empty or is being drained this cycle,
  // which is what lets each channel sustain one word per cycle.
  assign bus.in_ready = (state_q[bus.in_sel] == EMPTY) || sink_ready[bus.in_sel];

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    fill  = '0;
    drain = '0;
    for (int n = 0; n < 2; n++) begin
      fill[n]  = bus.in_valid && bus.in_ready && (int'(bus.in_sel) == n);
      drain[n] = (state_q[n] == FULL) && sink_ready[n];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '{EMPTY, EMPTY};
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples the pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  // Next-state logic: a fill wins over a drain, keeping the buffer full.
  always_comb begin
    state_d = state_q;
    for (int n = 0; n < 2; n++) begin
      if (fill[n]) begin
        state_d[n] = FULL;
      end else if (drain[n]) begin
        state_d[n] = EMPTY;
      end
    end
  end

  // Data and counter next-values.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int n = 0; n < 2; n++) begin
      if (fill[n]) begin
        data_d[n] = bus.in_data;
      end
      if (clr_cnt) begin
        cnt_d[n] = '0;
      end else if (fill[n] && (cnt_q[n] != CNT_MAX)) begin
        cnt_d[n] = cnt_q[n] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset too, because the buffered words must
      // read as zero during reset rather than merely be marked invalid.
      data_q <= '{'0, '0};
      cnt_q  <= '{'0, '0};
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  // Output logic.
  always_comb begin
    bus.out0_valid = (state_q[0] == FULL);
    bus.out1_valid = (state_q[1] == FULL);
    bus.out0_data  = data_q[0];
    bus.out1_data  = data_q[1];
    cnt0           = cnt_q[0];
    cnt1           = cnt_q[1];
  end

endmodule

// File: tb/tb_demux_router.sv
// Bench for demux_router: directed scenarios plus random traffic, checked by a
// negedge monitor against per-channel queues and saturating counts.
module tb_demux_router;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clr_cnt = 1'b0;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  demux_router_if #(.WIDTH(WIDTH)) bus ();

  demux_router #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .cnt0    (cnt0),
    .cnt1    (cnt1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: each channel is a queue of words accepted but not yet
  // consumed (at most one deep); counts are plain integers clamped at CNT_SAT.
  logic [WIDTH-1:0] mq [2][$];
  int               m_cnt [2];
  logic             exp_ready;
  logic [1:0]       rdy;
  logic [1:0]       vld;
  logic [WIDTH-1:0] odat [2];

  always @(negedge clk) begin
    if (!rst_n) begin
      mq[0].delete();
      mq[1].delete();
      m_cnt[0] = 0;
      m_cnt[1] = 0;
    end else begin
      rdy     = {bus.out1_ready, bus.out0_ready};
      vld     = {bus.out1_valid, bus.out0_valid};
      odat[0] = bus.out0_data;
      odat[1] = bus.out1_data;
      exp_ready = (mq[bus.in_sel].size() == 0) || rdy[bus.in_sel];
      check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
      check("cnt0", {24'b0, cnt0}, m_cnt[0]);
      check("cnt1", {24'b0, cnt1}, m_cnt[1]);
      for (int n = 0; n < 2; n++) begin
        check($sformatf("out%0d_valid", n), {31'b0, vld[n]}, {31'b0, mq[n].size() != 0});
        if (mq[n].size() != 0) begin
          check($sformatf("out%0d_data", n), {24'b0, odat[n]}, {24'b0, mq[n][0]});
          if (rdy[n]) void'(mq[n].pop_front());
        end
      end
      if (bus.in_valid && exp_ready) mq[bus.in_sel].push_back(bus.in_data);
      for (int n = 0; n < 2; n++) begin
        if (clr_cnt) m_cnt[n] = 0;
        else if (bus.in_valid && exp_ready && int'(bus.in_sel) == n && m_cnt[n] < CNT_SAT)
          m_cnt[n]++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic [WIDTH-1:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  initial begin
    drive(1'b0, 1'b0, '0);
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;

    // Steering.
    drive(1'b1, 1'b0, 8'hA5);
    step();
    check("steer_out0", {24'b0, bus.out0_data}, 32'hA5);
    drive(1'b1, 1'b1, 8'h3C);
    step();
    drive(1'b0, 1'b0, '0);
    check("steer_out1", {24'b0, bus.out1_data}, 32'h3C);
    check("steer_cnt0", {24'b0, cnt0}, 32'd1);
    check("steer_cnt1", {24'b0, cnt1}, 32'd1);
    step();

    // Back-pressure on channel 0.
    bus.out0_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h11);
    step();
    drive(1'b1, 1'b0, 8'h22);
    #1 check("bp_in_ready_low", {31'b0, bus.in_ready}, 32'd0);
    step();
    check("bp_hold", {24'b0, bus.out0_data}, 32'h11);
    bus.in_sel = 1'b1;
    #1 check("bp_other_free", {31'b0, bus.in_ready}, 32'd1);
    bus.in_sel = 1'b0;
    bus.out0_ready = 1'b1;
    #1 check("bp_release", {31'b0, bus.in_ready}, 32'd1);
    step();
    drive(1'b0, 1'b0, '0);
    check("bp_next", {24'b0, bus.out0_data}, 32'h22);
    check("bp_next_valid", {31'b0, bus.out0_valid}, 32'd1);
    step();

    // Streaming 20 words to channel 1.
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, WIDTH'(i));
      #1 check("stream_ready", {31'b0, bus.in_ready}, 32'd1);
      step();
    end
    drive(1'b0, 1'b0, '0);
    check("stream_cnt1", {24'b0, cnt1}, 32'd20);
    step();

    // Channel 0 stalled and full while channel 1 streams.
    bus.out0_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h5A);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 8'hC0 + 8'(i));
      step();
      check("indep_out0", {24'b0, bus.out0_data}, 32'h5A);
    end
    drive(1'b0, 1'b0, '0);
    bus.out0_ready = 1'b1;
    repeat (2) step();

    // Asynchronous reset with both buffers full.
    bus.out0_ready = 1'b0;
    bus.out1_ready = 1'b0;
    drive(1'b1, 1'b0, 8'h77);
    step();
    drive(1'b1, 1'b1, 8'h88);
    step();
    drive(1'b0, 1'b0, '0);
    rst_n = 1'b0;
    #1;
    check("rst_out0_valid", {31'b0, bus.out0_valid}, 32'd0);
    check("rst_out1_valid", {31'b0, bus.out1_valid}, 32'd0);
    check("rst_out0_data", {24'b0, bus.out0_data}, 32'd0);
    check("rst_out1_data", {24'b0, bus.out1_data}, 32'd0);
    check("rst_cnt0", {24'b0, cnt0}, 32'd0);
    check("rst_cnt1", {24'b0, cnt1}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;

    // Saturation and clear-over-increment.
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 1'b0, WIDTH'($urandom));
      step();
    end
    check("sat_cnt0", {24'b0, cnt0}, CNT_SAT);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    drive(1'b0, 1'b0, '0);
    check("clr_cnt0", {24'b0, cnt0}, 32'd0);
    step();

    // Random traffic.
    for (int i = 0; i < 1000; i++) begin
      drive(1'($urandom), 1'($urandom), WIDTH'($urandom));
      bus.out0_ready = ($urandom_range(0, 3) != 0);
      bus.out1_ready = ($urandom_range(0, 3) != 0);
      clr_cnt        = ($urandom_range(0, 49) == 0);
      step();
    end
    drive(1'b0, 1'b0, '0);
    clr_cnt = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    repeat (3) step();
    @(negedge clk);
    #1;
    check("final_empty0", {31'b0, bus.out0_valid}, 32'd0);
    check("final_empty1", {31'b0, bus.out1_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_router.md
# demux_router

Two-way stream demultiplexer with one-entry output buffering: the write-side counterpart to the processor's 2:1 operand mux. It accepts one data word per transfer on a valid/ready input channel and steers it, according to the select bit sent with the word, into one of two registered output channels. Each output channel has its own valid/ready handshake and a saturating transfer counter for debug. It sits between the execute stage and the two result sinks (register-file write port and store path).

## Interface

- WIDTH, 8, data word width in bits
- CNT_W, 8, width of each per-channel transfer counter

- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  input word
- in_sel  input  1  destination: 0 = channel 0, 1 = channel 1; qualified by in_valid
- in_valid  input  1  input word and in_sel are valid
- in_ready  output  1  router accepts the input word this cycle
- out0_data  output  WIDTH  channel 0 buffered word
- out0_valid  output  1  channel 0 buffer holds a word
- out0_ready  input  1  channel 0 sink accepts the word
- out1_data  output  WIDTH  channel 1 buffered word
- out1_valid  output  1  channel 1 buffer holds a word
- out1_ready  input  1  channel 1 sink accepts the word
- cnt0  output  CNT_W  words accepted for channel 0, saturating
- cnt1  output  CNT_W  words accepted for channel 1, saturating
- clr_cnt  input  1  synchronous clear of cnt0 and cnt1

## Operation

- Each channel N holds a one-entry buffer: a data register (outN_data) and a full flag (outN_valid). Per-channel state is EMPTY (valid=0) or FULL (valid=1).
- Input acceptance: in_ready = !outS_valid || outS_ready, where S = in_sel. in_ready is combinational from in_sel, out0_valid/out1_valid and out0_ready/out1_ready. It does not depend on in_valid.
- Transfer on input: in_valid && in_ready. The word is written into buffer S, and outS_valid is 1 on the next cycle.
- Drain on channel N: outN_valid && outN_ready. The buffer becomes EMPTY unless a new word for N is accepted in the same cycle.
- Simultaneous drain and fill on the same channel: the buffer stays FULL with the new word. This gives full throughput of 1 word/cycle per channel.
- The non-selected channel is unaffected by the input. It may drain in the same cycle the other channel fills.
- outN_data holds its value while outN_valid=1 && outN_ready=0. The value is don't-care while valid=0, but the register only loads on an accepted transfer.
- Counters: cntS increments by 1 on each accepted input transfer to channel S. A counter at 2^CNT_W−1 holds that value. clr_cnt=1 forces both counters to 0 and takes priority over an increment in the same cycle.
- No reordering within a channel. No word is dropped or duplicated.

## Timing

- Reset (rst_n=0, asynchronous): out0_valid=0, out1_valid=0, out0_data=0, out1_data=0, cnt0=0, cnt1=0. in_ready then evaluates to 1.
- Reset release: the first transfer can be accepted on the first rising edge with rst_n=1.
- Latency: a word accepted at edge k appears on outS_data with outS_valid=1 after edge k. It can be consumed at edge k+1.
- Back-pressure: if outS_valid=1 and outS_ready=0, in_ready=0 for in_sel=S only. in_sel toggling to the free channel makes in_ready=1 in the same cycle.
- Reset asserted mid-transfer: any buffered words are discarded and both counters are zeroed immediately. The upstream source must resend them.
- Counter update is visible the cycle after the accepting edge, aligned with outS_valid.

## Test plan

- Reset: drive rst_n=0 with buffers previously full -> all valids 0, data 0, counts 0 without a clock edge; in_ready=1.
- Steering: send 0xA5 with sel=0, then 0x3C with sel=1, both sinks ready -> out0_data=0xA5 one cycle later, then out1_data=0x3C; cnt0=1, cnt1=1.
- Back-pressure: out0_ready=0, send 0x11 then 0x22 on sel=0 -> 0x11 held, in_ready=0 for the second word; raise out0_ready -> 0x11 drains and 0x22 is accepted in the same cycle, with 0x22 visible next cycle.
- Streaming: 20 consecutive words 0x00..0x13 on sel=1 with out1_ready=1 -> one word per cycle, in order, in_ready constantly 1, cnt1=20.
- Independence: channel 0 stalled and full, stream 5 words to sel=1 -> all 5 delivered, out0_data unchanged.
- Saturation/clear: 300 transfers to channel 0 with CNT_W=8 -> cnt0=255; clr_cnt=1 coincident with a transfer -> cnt0=0.
